// File: rtl/lifo_pkg.sv
// Shared operation encoding and modulo pointer helpers for the LIFO.
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_REPLACE,
    OP_PUSH,
    OP_POP
  } lifo_op_e;

  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned p, input int unsigned n);
    return (p == 0) ? n - 1 : p - 1;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// LIFO storage: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
// No reset; the controller masks stale contents via its entry count.
module lifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo.sv
// LIFO controller: stack pointer, entry count and overflow/underflow flags.
// r_sp addresses the next free slot; the top entry sits one slot below, modulo DEPTH.
module lifo
  import lifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_sp;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  lifo_op_e         w_op;
  logic [PTR_W-1:0] w_sp_inc;
  logic [PTR_W-1:0] w_top;
  logic [PTR_W-1:0] w_sp_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;
  logic [WIDTH-1:0] w_rdata;
  logic             w_empty;
  logic             w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_sp_inc = PTR_W'(wrap_inc(32'(r_sp), DEPTH));
  assign w_top    = PTR_W'(wrap_dec(32'(r_sp), DEPTH));

  always_comb begin
    w_op = OP_IDLE;
    if (flush)              w_op = OP_FLUSH;
    else if (push && pop)   w_op = w_empty ? OP_PUSH : OP_REPLACE;
    else if (push)          w_op = OP_PUSH;
    else if (pop)           w_op = OP_POP;
  end

  always_comb begin
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_count;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    w_we      = 1'b0;
    w_waddr   = r_sp;
    unique case (w_op)
      OP_FLUSH: begin
        w_sp_nxt  = '0;
        w_cnt_nxt = '0;
      end
      OP_REPLACE: begin
        w_we    = 1'b1;
        w_waddr = w_top;
      end
      OP_PUSH: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_sp_nxt  = w_sp_inc;
          w_cnt_nxt = r_count + CNT_W'(1);
        end else begin
          w_ovf_nxt = 1'b1;
          // In circular mode the free slot above the top is the oldest entry.
          if (WRAP != 0) begin
            w_we     = 1'b1;
            w_sp_nxt = w_sp_inc;
          end
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_sp_nxt  = w_top;
          w_cnt_nxt = r_count - CNT_W'(1);
        end else begin
          w_unf_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_sp    <= w_sp_nxt;
      r_count <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_raddr (w_top),
    .o_rdata (w_rdata)
  );

  assign dout  = w_empty ? '0 : w_rdata;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_lifo.sv
// Directed bench: a saturating and a circular LIFO (WIDTH=8, DEPTH=4) driven by shared stimulus.
module tb_lifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic [2:0] count0, count1;
  logic       empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

  int n_cmp = 0;
  int n_bad = 0;

  lifo #(.WIDTH(8), .DEPTH(4), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .din(din),
    .dout(dout0), .count(count0), .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0)
  );

  lifo #(.WIDTH(8), .DEPTH(4), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .din(din),
    .dout(dout1), .count(count1), .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic f, input logic [7:0] d);
    @(negedge clk);
    push = p; pop = q; flush = f; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_both(input string tag, input logic [7:0] d, input logic [2:0] c,
                          input logic e, input logic fu, input logic o, input logic u);
    chk({tag, ".w0.dout"},  32'(dout0),  32'(d));
    chk({tag, ".w0.count"}, 32'(count0), 32'(c));
    chk({tag, ".w0.empty"}, 32'(empty0), 32'(e));
    chk({tag, ".w0.full"},  32'(full0),  32'(fu));
    chk({tag, ".w0.ovf"},   32'(ovf0),   32'(o));
    chk({tag, ".w0.unf"},   32'(unf0),   32'(u));
    chk({tag, ".w1.dout"},  32'(dout1),  32'(d));
    chk({tag, ".w1.count"}, 32'(count1), 32'(c));
    chk({tag, ".w1.empty"}, 32'(empty1), 32'(e));
    chk({tag, ".w1.full"},  32'(full1),  32'(fu));
    chk({tag, ".w1.ovf"},   32'(ovf1),   32'(o));
    chk({tag, ".w1.unf"},   32'(unf1),   32'(u));
  endtask

  initial begin
    logic [7:0] vals [4];
    logic [7:0] pop0 [4];
    logic [7:0] pop1 [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    #3;
    chk_both("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Fill, then drain in reverse order.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, vals[i]);
      chk_both($sformatf("fill%0d", i), vals[i], 3'(i + 1), 1'b0, (i == 3), 1'b0, 1'b0);
    end
    pop0 = '{8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk_both($sformatf("drain%0d", i), pop0[i], 3'(3 - i), (i == 3), 1'b0, 1'b0, 1'b0);
    end

    // Overflow: saturating keeps 0x44 on top, circular overwrites oldest with 0x55.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, vals[i]);
    step(1'b1, 1'b0, 1'b0, 8'h55);
    chk("ovf.w0.flag",  32'(ovf0),   32'd1);
    chk("ovf.w1.flag",  32'(ovf1),   32'd1);
    chk("ovf.w0.dout",  32'(dout0),  32'h44);
    chk("ovf.w1.dout",  32'(dout1),  32'h55);
    chk("ovf.w0.count", 32'(count0), 32'd4);
    chk("ovf.w1.count", 32'(count1), 32'd4);
    chk("ovf.w0.full",  32'(full0),  32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf.w0.clear", 32'(ovf0), 32'd0);
    chk("ovf.w1.clear", 32'(ovf1), 32'd0);
    pop0 = '{8'h33, 8'h22, 8'h11, 8'h00};
    pop1 = '{8'h44, 8'h33, 8'h22, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      chk($sformatf("ovpop%0d.w0.dout", i), 32'(dout0),  32'(pop0[i]));
      chk($sformatf("ovpop%0d.w1.dout", i), 32'(dout1),  32'(pop1[i]));
      chk($sformatf("ovpop%0d.count", i),   32'(count1), 32'(3 - i));
    end
    chk("ovpop.w0.empty", 32'(empty0), 32'd1);
    chk("ovpop.w1.empty", 32'(empty1), 32'd1);

    // Underflow and simultaneous push/pop.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk_both("unf", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h66);
    chk_both("pp_empty", 8'h66, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    chk_both("pp_replace", 8'h77, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Flush wins over push.
    step(1'b1, 1'b0, 1'b0, 8'h88);
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    chk_both("three", 8'hAA, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hBB);
    chk_both("flush", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h99);
    chk_both("after_flush", 8'h99, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with two entries held.
    step(1'b1, 1'b0, 1'b0, 8'h12);
    chk_both("two", 8'h12, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk_both("async_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    chk_both("post_rst", 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
